uart_lb_deframer: RTL and testbench

- Receive-side counterpart of the host command stream sent over the USB-UART link.
- Takes the byte stream from the UART receiver (rxdata/rxvalid) and locks onto the sync preamble.
- Reassembles 64-bit local-bus command words {cmd[7:0], addr[23:0], data[31:0]}, MSB byte first.
- Buffers completed words in a small FIFO and presents them to the local-bus master with a valid/ready handshake.
- Sits between the uart block and the lb command decoder in qubichw_config, clocked by uartclk.

---
 rtl/uart_lb_deframer.sv | 188 ++++++++++++++++++
 tb/tb_uart_lb_deframer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_lb_deframer.sv
// Purpose : lock onto the 0xff..0xff,0x00 preamble in the UART byte stream and
//           reassemble MSB-first NBYTE-byte local-bus command words into a FWFT FIFO.
// Latency : cmdvalid rises on the first edge after the edge that samples the last byte.
// Backpr. : cmd/cmdvalid hold while cmdready is low; a word arriving at a full FIFO is
//           dropped, sets the sticky overflow flag and bumps errcnt.
// Ports   : clk, rstn (async active-low) | rxdata/rxvalid byte strobe in |
//           cmd/cmdvalid/cmdready command out | synced, overflow, errcnt status.
// Option  : define UART_LB_DEFRAMER_TIMEOUT_EN to discard partial words idle for
//           TIMEOUT cycles (counted in errcnt).
module uart_lb_deframer #(
  parameter int NBYTE   = 8,
  parameter int FIFO_AW = 2,
  parameter int NSYNCFF = 15,
  parameter int TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [7:0]           rxdata,
  input  logic                 rxvalid,
  output logic [8*NBYTE-1:0]   cmd,
  output logic                 cmdvalid,
  input  logic                 cmdready,
  output logic                 synced,
  output logic                 overflow,
  output logic [15:0]          errcnt
);

  localparam int W     = 8 * NBYTE;
  localparam int BCW   = (NBYTE > 1) ? $clog2(NBYTE) : 1;
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [BCW-1:0] LAST   = BCW'(NBYTE - 1);
  localparam logic [W-1:0]   W_ONES = '1;
  localparam logic [W-1:0]   W_SYNC = {{(W-8){1'b1}}, 8'h00};

  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [4:0]       r_ffcnt, w_ffcnt_nxt;
  logic [BCW-1:0]   r_bytecnt, w_bytecnt_nxt, w_cnt_eff;
  logic [W-1:0]     r_asm, w_asm_nxt, w_word;
  logic             w_push_nxt;
  logic             w_tmo;

  // Completed word staged one cycle before it enters the FIFO.
  logic             r_pvld;
  logic [W-1:0]     r_pdat;

  logic [W-1:0]     r_mem [DEPTH];
  logic [FIFO_AW:0] r_wptr, r_rptr;
  logic             w_empty, w_full, w_pop, w_wr, w_drop;

  logic             r_overflow;
  logic [15:0]      r_errcnt;
  logic [16:0]      w_err_sum;

  assign w_word = {r_asm[W-9:0], rxdata};

  // A byte that lands together with a timeout starts a fresh word.
  assign w_cnt_eff = w_tmo ? '0 : r_bytecnt;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= HUNT;
      r_ffcnt   <= '0;
      r_bytecnt <= '0;
      r_asm     <= '0;
      r_pvld    <= 1'b0;
      r_pdat    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ffcnt   <= w_ffcnt_nxt;
      r_bytecnt <= w_bytecnt_nxt;
      r_asm     <= w_asm_nxt;
      r_pvld    <= w_push_nxt;
      if (w_push_nxt) r_pdat <= w_word;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ffcnt_nxt   = r_ffcnt;
    w_bytecnt_nxt = w_cnt_eff;
    w_asm_nxt     = r_asm;
    w_push_nxt    = 1'b0;
    case (r_state)
      HUNT: begin
        if (rxvalid) begin
          if (rxdata == 8'hff) begin
            if (r_ffcnt != 5'd31) w_ffcnt_nxt = r_ffcnt + 5'd1;
          end else if (rxdata == 8'h00 && r_ffcnt >= 5'(NSYNCFF)) begin
            w_state_nxt   = RUN;
            w_ffcnt_nxt   = '0;
            w_bytecnt_nxt = '0;
          end else begin
            w_ffcnt_nxt = '0;
          end
        end
      end
      RUN: begin
        if (rxvalid) begin
          w_asm_nxt = w_word;
          if (w_cnt_eff != LAST) begin
            w_bytecnt_nxt = w_cnt_eff + BCW'(1);
          end else begin
            w_bytecnt_nxt = '0;
            if (w_word == W_ONES) begin
              // The eight 0xff bytes already count towards the next preamble,
              // so an aligned ..ff00 word relocks without losing a command.
              w_state_nxt = HUNT;
              w_ffcnt_nxt = 5'd8;
            end else if (w_word != W_SYNC) begin
              w_push_nxt = 1'b1;
            end
          end
        end
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  // ---------------------------------------------------------- idle timeout
`ifdef UART_LB_DEFRAMER_TIMEOUT_EN
  localparam logic [15:0] TMO = 16'(TIMEOUT);
  logic [15:0] r_idle;

  assign w_tmo = (r_state == RUN) && (r_bytecnt != '0) && (r_idle == TMO);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_idle <= '0;
    end else if (r_state != RUN || r_bytecnt == '0 || rxvalid || w_tmo) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + 16'd1;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  // ---------------------------------------------------------------- FIFO
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[FIFO_AW] != r_rptr[FIFO_AW]) &&
                   (r_wptr[FIFO_AW-1:0] == r_rptr[FIFO_AW-1:0]);
  assign w_pop   = ~w_empty & cmdready;
  // When full, a simultaneous pop frees the head slot the write lands in.
  assign w_wr    = r_pvld & (~w_full | w_pop);
  assign w_drop  = r_pvld & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr) begin
      r_mem[r_wptr[FIFO_AW-1:0]] <= r_pdat;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
    end
  end

  // -------------------------------------------------------------- status
  assign w_err_sum = {1'b0, r_errcnt} + 17'(w_drop) + 17'(w_tmo);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_overflow <= 1'b0;
      r_errcnt   <= '0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      r_errcnt <= w_err_sum[16] ? 16'hffff : w_err_sum[15:0];
    end
  end

  assign cmd      = r_mem[r_rptr[FIFO_AW-1:0]];
  assign cmdvalid = ~w_empty;
  assign synced   = (r_state == RUN);
  assign overflow = r_overflow;
  assign errcnt   = r_errcnt;

endmodule

// File: tb/tb_uart_lb_deframer.sv
// Self-checking bench for uart_lb_deframer: a vector table of command words sent
// back-to-back, plus directed sequences for lock, overflow, resync, partial words
// (idle timeout when UART_LB_DEFRAMER_TIMEOUT_EN is defined) and mid-word reset.
module tb_uart_lb_deframer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  rxdata = 8'h00;
  logic        rxvalid = 1'b0;
  logic [63:0] cmd;
  logic        cmdvalid;
  logic        cmdready = 1'b0;
  logic        synced;
  logic        overflow;
  logic [15:0] errcnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] q[$];

  uart_lb_deframer #(
    .NBYTE(8), .FIFO_AW(2), .NSYNCFF(15), .TIMEOUT(100)
  ) dut (
    .clk(clk), .rstn(rstn), .rxdata(rxdata), .rxvalid(rxvalid),
    .cmd(cmd), .cmdvalid(cmdvalid), .cmdready(cmdready),
    .synced(synced), .overflow(overflow), .errcnt(errcnt)
  );

  always #5 clk = ~clk;

  // Inputs only change just after a rising edge, so the falling edge sees the
  // handshake exactly as the next rising edge will.
  always @(negedge clk) begin
    if (rstn && cmdvalid && cmdready) q.push_back(cmd);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxdata  = b;
    rxvalid = 1'b1;
    @(posedge clk);
    #1;
    rxvalid = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] w);
    for (int i = 7; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic send_preamble(input int nff);
    for (int i = 0; i < nff; i++) send_byte(8'hff);
    send_byte(8'h00);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    #2;
    rstn = 1'b0;
    idle(2);
    rstn = 1'b1;
    idle(1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " cmd"},      cmd,             64'h0);
    chk({tag, " cmdvalid"}, 64'(cmdvalid),   64'h0);
    chk({tag, " synced"},   64'(synced),     64'h0);
    chk({tag, " overflow"}, 64'(overflow),   64'h0);
    chk({tag, " errcnt"},   64'(errcnt),     64'h0);
  endtask

  typedef struct {
    logic [63:0] word;
    logic        out_exp;
  } vec_t;

  vec_t vt[6];
  logic [63:0] exp_q[$];
  logic [63:0] ovf_w[5];

  initial begin
    vt[0] = '{64'h0100000a00000013, 1'b1};
    vt[1] = '{64'h00000000facefeed, 1'b1};
    vt[2] = '{64'h00000001deadbeef, 1'b1};
    vt[3] = '{64'hffffffffffffff00, 1'b0};  // in-run sync word, swallowed
    vt[4] = '{64'h0000000000000000, 1'b1};
    vt[5] = '{64'hfffffffffffffffe, 1'b1};

    ovf_w[0] = 64'h1111111111111111;
    ovf_w[1] = 64'h2222222222222222;
    ovf_w[2] = 64'h3333333333333333;
    ovf_w[3] = 64'h4444444444444444;
    ovf_w[4] = 64'h5555555555555555;

    // Reset state
    #1;
    chk_reset_outputs("reset");
    idle(2);
    rstn = 1'b1;
    idle(1);

    // False preamble: 14 x ff is one short
    send_preamble(14);
    chk("false_pre synced", 64'(synced), 64'h0);
    send_word(64'h0100001700e02281);
    idle(3);
    chk("false_pre cmdvalid", 64'(cmdvalid), 64'h0);

    // Lock and first word with exact latency
    for (int i = 0; i < 15; i++) send_byte(8'hff);
    chk("lock synced before 00", 64'(synced), 64'h0);
    send_byte(8'h00);
    chk("lock synced", 64'(synced), 64'h1);
    send_word(64'h0100001700e02281);
    chk("first cmdvalid same cycle", 64'(cmdvalid), 64'h0);
    idle(1);
    chk("first cmdvalid", 64'(cmdvalid), 64'h1);
    chk("first cmd", cmd, 64'h0100001700e02281);
    idle(2);
    chk("first cmd held", cmd, 64'h0100001700e02281);
    cmdready = 1'b1;
    idle(3);
    chk("first accepts", 64'(q.size()), 64'd1);
    if (q.size() > 0) chk("first accept value", q[0], 64'h0100001700e02281);
    q.delete();

    // Table: back-to-back words with cmdready high
    foreach (vt[i]) begin
      send_word(vt[i].word);
      if (vt[i].out_exp) exp_q.push_back(vt[i].word);
    end
    idle(4);
    chk("table accepts", 64'(q.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) if (i < q.size()) chk($sformatf("table word %0d", i), q[i], exp_q[i]);
    chk("table errcnt", 64'(errcnt), 64'h0);
    chk("table synced", 64'(synced), 64'h1);
    q.delete();

    // Overflow: four held, fifth dropped
    cmdready = 1'b0;
    foreach (ovf_w[i]) send_word(ovf_w[i]);
    idle(3);
    chk("ovf cmdvalid", 64'(cmdvalid), 64'h1);
    chk("ovf head", cmd, ovf_w[0]);
    chk("ovf flag", 64'(overflow), 64'h1);
    chk("ovf errcnt", 64'(errcnt), 64'h1);
    cmdready = 1'b1;
    idle(8);
    chk("ovf drained count", 64'(q.size()), 64'd4);
    for (int i = 0; i < 4; i++) if (i < q.size()) chk($sformatf("ovf drain %0d", i), q[i], ovf_w[i]);
    chk("ovf empty", 64'(cmdvalid), 64'h0);
    chk("ovf flag sticky", 64'(overflow), 64'h1);
    q.delete();

    // Resync mid-stream, misaligned by three stray bytes: the first word passes,
    // the next is all-ones (back to HUNT with 8 counted), and the remaining
    // ff ff 00 falls short of 15, so the command bytes are ignored.
    send_byte(8'haa); send_byte(8'hbb); send_byte(8'hcc);
    send_word(64'hffffffffffffffff);
    send_word(64'hffffffffffffff00);
    send_word(64'h0100001500000000);
    idle(4);
    chk("resync mis accepts", 64'(q.size()), 64'd1);
    if (q.size() > 0) chk("resync mis word", q[0], 64'haabbccffffffffff);
    chk("resync mis synced", 64'(synced), 64'h0);
    q.delete();
    // Fresh preamble relocks; then the aligned resync path loses nothing.
    send_preamble(15);
    chk("relock synced", 64'(synced), 64'h1);
    send_word(64'hffffffffffffffff);
    chk("aligned ones synced", 64'(synced), 64'h0);
    send_word(64'hffffffffffffff00);
    chk("aligned relock synced", 64'(synced), 64'h1);
    send_word(64'h0100001500000000);
    idle(4);
    chk("resync accepts", 64'(q.size()), 64'd1);
    if (q.size() > 0) chk("resync word", q[0], 64'h0100001500000000);
    chk("resync errcnt", 64'(errcnt), 64'h1);
    q.delete();

    // Partial word left idle
    do_reset();
    chk("reset2 overflow", 64'(overflow), 64'h0);
    chk("reset2 errcnt", 64'(errcnt), 64'h0);
    send_preamble(15);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
`ifdef UART_LB_DEFRAMER_TIMEOUT_EN
    idle(100);
    send_word(64'h0200000000000042);
    idle(4);
    chk("tmo errcnt", 64'(errcnt), 64'h1);
    chk("tmo accepts", 64'(q.size()), 64'd1);
    if (q.size() > 0) chk("tmo word", q[0], 64'h0200000000000042);
`else
    idle(200);
    send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
    send_byte(8'h77); send_byte(8'h88);
    idle(4);
    chk("wait errcnt", 64'(errcnt), 64'h0);
    chk("wait accepts", 64'(q.size()), 64'd1);
    if (q.size() > 0) chk("wait word", q[0], 64'h1122334455667788);
`endif
    chk("partial synced", 64'(synced), 64'h1);
    q.delete();

    // Reset asserted mid-word with a word waiting in the FIFO
    cmdready = 1'b0;
    send_word(64'h0300000000000077);
    idle(2);
    send_byte(8'h99); send_byte(8'h98); send_byte(8'h97);
    #3;
    rstn = 1'b0;
    #1;
    chk_reset_outputs("midword reset");
    idle(2);
    rstn = 1'b1;
    cmdready = 1'b1;
    send_preamble(15);
    send_word(64'h0400000000000001);
    idle(4);
    chk("post reset accepts", 64'(q.size()), 64'd1);
    if (q.size() > 0) chk("post reset word", q[0], 64'h0400000000000001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
